// File: rtl/char_writer_if.sv
// Host-side byte stream plus character-buffer write port and cursor/scroll status.
// The host (master) drives data/valid; char_writer (slave) drives everything else.
interface char_writer_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        data;
    logic              valid;
    logic              ready;
    logic [7:0]        din;
    logic [ADDR_W-1:0] waddr;
    logic              write_en;
    logic [6:0]        cursor_x;
    logic [4:0]        cursor_y;
    logic [4:0]        first_row;

    modport master (
        output data, valid,
        input  ready, din, waddr, write_en, cursor_x, cursor_y, first_row
    );

    modport slave (
        input  data, valid,
        output ready, din, waddr, write_en, cursor_x, cursor_y, first_row
    );
endinterface

// File: rtl/char_writer.sv
// VT52-style write controller for a COLS x ROWS character buffer: prints bytes at the
// cursor, handles cursor/scroll control codes, and blanks ranges with a one-cell-per-cycle fill.
module char_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int ADDR_W = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    char_writer_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ESC  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

    logic [1:0]        state_q, state_d;
    logic [6:0]        cx_q, cx_d;
    logic [4:0]        cy_q, cy_d;
    logic [4:0]        first_row_q, first_row_d;
    logic [6:0]        fill_x_q, fill_x_d;
    logic [4:0]        fill_y_q, fill_y_d;
    logic [4:0]        end_y_q, end_y_d;
    logic              home_q, home_d;
    logic [7:0]        din_q, din_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              we_q, we_d;
    logic              accept;

    // Logical (col, row) to physical buffer address, rotating rows by the scroll offset.
    function automatic logic [ADDR_W-1:0] phys_addr(input logic [6:0] col,
                                                    input logic [4:0] row,
                                                    input logic [4:0] fr);
        logic [5:0] sum;
        logic [4:0] prow;
        sum  = {1'b0, fr} + {1'b0, row};
        prow = (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];
        return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    assign bus.ready     = (state_q != ST_FILL);
    assign accept        = bus.valid && bus.ready;
    assign bus.din       = din_q;
    assign bus.waddr     = waddr_q;
    assign bus.write_en  = we_q;
    assign bus.cursor_x  = cx_q;
    assign bus.cursor_y  = cy_q;
    assign bus.first_row = first_row_q;

    always_comb begin
        // NOTE: every _d gets a hold-value default first so no path can infer a latch.
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        first_row_d = first_row_q;
        fill_x_d    = fill_x_q;
        fill_y_d    = fill_y_q;
        end_y_d     = end_y_q;
        home_d      = home_q;
        din_d       = din_q;
        waddr_d     = waddr_q;
        we_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.data >= 8'h20 && bus.data <= 8'h7E) begin
                        din_d   = bus.data;
                        waddr_d = phys_addr(cx_q, cy_q, first_row_q);
                        we_d    = 1'b1;
                        if (cx_q < X_MAX) cx_d = cx_q + 7'd1;
                    end else begin
                        case (bus.data)
                            8'h08: if (cx_q != 7'd0) cx_d = cx_q - 7'd1;
                            8'h0D: cx_d = 7'd0;
                            8'h0A: begin
                                if (cy_q < Y_MAX) begin
                                    cy_d = cy_q + 5'd1;
                                end else begin
                                    // Scroll: the new bottom row reuses the old top physical row.
                                    first_row_d = (first_row_q == Y_MAX) ? 5'd0 : first_row_q + 5'd1;
                                    fill_x_d    = 7'd0;
                                    fill_y_d    = Y_MAX;
                                    end_y_d     = Y_MAX;
                                    home_d      = 1'b0;
                                    state_d     = ST_FILL;
                                end
                            end
                            8'h0C: begin
                                fill_x_d = 7'd0;
                                fill_y_d = 5'd0;
                                end_y_d  = Y_MAX;
                                home_d   = 1'b1;
                                state_d  = ST_FILL;
                            end
                            8'h1B:   state_d = ST_ESC;
                            default: ;
                        endcase
                    end
                end
            end

            ST_ESC: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    case (bus.data)
                        "H": begin
                            cx_d = 7'd0;
                            cy_d = 5'd0;
                        end
                        "K", "J": begin
                            fill_x_d = cx_q;
                            fill_y_d = cy_q;
                            end_y_d  = (bus.data == "K") ? cy_q : Y_MAX;
                            home_d   = 1'b0;
                            state_d  = ST_FILL;
                        end
                        "A":     if (cy_q != 5'd0) cy_d = cy_q - 5'd1;
                        "B":     if (cy_q < Y_MAX) cy_d = cy_q + 5'd1;
                        "C":     if (cx_q < X_MAX) cx_d = cx_q + 7'd1;
                        "D":     if (cx_q != 7'd0) cx_d = cx_q - 7'd1;
                        default: ;
                    endcase
                end
            end

            ST_FILL: begin
                din_d   = 8'h20;
                waddr_d = phys_addr(fill_x_q, fill_y_q, first_row_q);
                we_d    = 1'b1;
                if (fill_x_q == X_MAX && fill_y_q == end_y_q) begin
                    state_d = ST_IDLE;
                    if (home_q) begin
                        first_row_d = 5'd0;
                        cx_d        = 7'd0;
                        cy_d        = 5'd0;
                    end
                end else if (fill_x_q == X_MAX) begin
                    fill_x_d = 7'd0;
                    fill_y_d = fill_y_q + 5'd1;
                end else begin
                    fill_x_d = fill_x_q + 7'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Reset parks the FSM in a whole-screen fill so the power-up clear starts on release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_FILL;
            cx_q        <= 7'd0;
            cy_q        <= 5'd0;
            first_row_q <= 5'd0;
            fill_x_q    <= 7'd0;
            fill_y_q    <= 5'd0;
            end_y_q     <= Y_MAX;
            home_q      <= 1'b1;
            din_q       <= 8'd0;
            waddr_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            first_row_q <= first_row_d;
            fill_x_q    <= fill_x_d;
            fill_y_q    <= fill_y_d;
            end_y_q     <= end_y_d;
            home_q      <= home_d;
            din_q       <= din_d;
            waddr_q     <= waddr_d;
            we_q        <= we_d;
        end
    end
endmodule

// File: tb/tb_char_writer.sv
// Directed bench for char_writer: printing, cursor control, scroll, ESC fills, clear and reset.
// Writes are logged on the falling edge; stimulus runs 1 ns after each falling edge.
module tb_char_writer;
    logic clk = 1'b0;
    logic reset_n;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int log_addr[$];
    int log_din[$];
    int log_cyc[$];

    char_writer_if #(.ADDR_W(11)) bus ();

    char_writer #(.COLS(80), .ROWS(25), .ADDR_W(11)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.write_en === 1'b1) begin
            log_addr.push_back(int'(bus.waddr));
            log_din.push_back(int'(bus.din));
            log_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_din.delete();
        log_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bus.ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready_timeout: ready=%b after %0d cycles, expected 1", bus.ready, n);
        end
        bus.data  = b;
        bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
    endtask

    task automatic send_esc(input logic [7:0] b);
        send_byte(8'h1B);
        send_byte(b);
    endtask

    // Waits out a fill and checks duration, write count and every address against the map.
    task automatic check_fill(input string name, input int sx, input int sy,
                              input int fr, input int len);
        int low, x, y, bad, exp_a, bad_i, bad_a, bad_e;
        low = 0; x = sx; y = sy; bad = 0; bad_i = -1; bad_a = 0; bad_e = 0;
        while (bus.ready !== 1'b1 && low < 4000) begin
            low++;
            tick();
        end
        n_cmp++;
        if (low !== len) begin
            n_bad++;
            $display("FAIL %s_ready_low: got %0d cycles, expected %0d", name, low, len);
        end
        n_cmp++;
        if (log_addr.size() !== len) begin
            n_bad++;
            $display("FAIL %s_write_count: got %0d, expected %0d", name, log_addr.size(), len);
        end
        for (int i = 0; i < log_addr.size() && i < len; i++) begin
            exp_a = ((fr + y) % 25) * 80 + x;
            if (log_addr[i] !== exp_a || log_din[i] !== 32'h20 || log_cyc[i] !== log_cyc[0] + i) begin
                if (bad == 0) begin
                    bad_i = i;
                    bad_a = log_addr[i];
                    bad_e = exp_a;
                end
                bad++;
            end
            if (x == 79) begin
                x = 0;
                y++;
            end else begin
                x++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s_sequence: %0d bad writes, first at index %0d addr %0d (din %0h), expected addr %0d din 20 gap-free",
                     name, bad, bad_i, bad_a, log_din[bad_i], bad_e);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.valid = 1'b0;
        bus.data  = 8'h00;
        repeat (3) tick();
        n_cmp++;
        if (bus.ready !== 1'b0 || bus.write_en !== 1'b0 || bus.waddr !== 11'd0 || bus.din !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%b write_en=%b waddr=%0d din=%0h, expected 0 0 0 0",
                     bus.ready, bus.write_en, bus.waddr, bus.din);
        end
        n_cmp++;
        if (bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd0 || bus.first_row !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_cursor: x=%0d y=%0d first_row=%0d, expected 0 0 0",
                     bus.cursor_x, bus.cursor_y, bus.first_row);
        end
        clear_log();
        reset_n = 1'b1;
        check_fill("power_up", 0, 0, 0, 2000);
        n_cmp++;
        if (bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd0 || bus.ready !== 1'b1) begin
            n_bad++;
            $display("FAIL power_up_done: x=%0d y=%0d ready=%b, expected 0 0 1",
                     bus.cursor_x, bus.cursor_y, bus.ready);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_byte("A");
        n_cmp++;
        if (bus.cursor_x !== 7'd1) begin
            n_bad++;
            $display("FAIL print_a_cursor: x=%0d, expected 1", bus.cursor_x);
        end
        send_byte("B");
        n_cmp++;
        if (bus.cursor_x !== 7'd2 || bus.cursor_y !== 5'd0) begin
            n_bad++;
            $display("FAIL print_ab_cursor: x=%0d y=%0d, expected 2 0", bus.cursor_x, bus.cursor_y);
        end
        send_byte(8'h0D);
        n_cmp++;
        if (bus.cursor_x !== 7'd0) begin
            n_bad++;
            $display("FAIL cr_cursor: x=%0d, expected 0", bus.cursor_x);
        end
        n_cmp++;
        if (log_addr.size() !== 2 || log_addr[0] !== 0 || log_din[0] !== 32'h41 ||
            log_addr[1] !== 1 || log_din[1] !== 32'h42 || log_cyc[1] !== log_cyc[0] + 1) begin
            n_bad++;
            $display("FAIL print_ab_writes: %0d writes, first %0h@%0d second %0h@%0d, expected 41@0 42@1 consecutive",
                     log_addr.size(), (log_din.size() > 0) ? log_din[0] : -1, (log_addr.size() > 0) ? log_addr[0] : -1,
                     (log_din.size() > 1) ? log_din[1] : -1, (log_addr.size() > 1) ? log_addr[1] : -1);
        end
    endtask

    task automatic test_no_wrap();
        clear_log();
        for (int i = 0; i < 81; i++) send_byte("x");
        n_cmp++;
        if (log_addr.size() !== 81 || log_addr[78] !== 78 || log_addr[79] !== 79 || log_addr[80] !== 79) begin
            n_bad++;
            $display("FAIL no_wrap_addrs: %0d writes, tail %0d %0d %0d, expected 81 writes tail 78 79 79",
                     log_addr.size(), (log_addr.size() > 78) ? log_addr[78] : -1,
                     (log_addr.size() > 79) ? log_addr[79] : -1, (log_addr.size() > 80) ? log_addr[80] : -1);
        end
        n_cmp++;
        if (bus.cursor_x !== 7'd79) begin
            n_bad++;
            $display("FAIL no_wrap_cursor: x=%0d, expected 79", bus.cursor_x);
        end
        send_byte(8'h0D);
    endtask

    task automatic test_controls();
        clear_log();
        send_byte("a");
        send_byte("b");
        send_byte("c");
        send_byte(8'h08);
        n_cmp++;
        if (bus.cursor_x !== 7'd2) begin
            n_bad++;
            $display("FAIL bs_cursor: x=%0d, expected 2", bus.cursor_x);
        end
        send_byte(8'h07);
        send_byte(8'h7F);
        send_byte(8'h00);
        send_esc("C");
        send_esc("C");
        send_esc("D");
        n_cmp++;
        if (bus.cursor_x !== 7'd3) begin
            n_bad++;
            $display("FAIL esc_cd_cursor: x=%0d, expected 3", bus.cursor_x);
        end
        send_esc("A");
        send_esc("B");
        send_esc("B");
        send_esc("B");
        send_esc("A");
        n_cmp++;
        if (bus.cursor_y !== 5'd2) begin
            n_bad++;
            $display("FAIL esc_ab_cursor: y=%0d, expected 2", bus.cursor_y);
        end
        send_esc("H");
        send_byte(8'h08);
        n_cmp++;
        if (bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd0) begin
            n_bad++;
            $display("FAIL esc_h_cursor: x=%0d y=%0d, expected 0 0", bus.cursor_x, bus.cursor_y);
        end
        n_cmp++;
        if (log_addr.size() !== 3 || log_addr[2] !== 2 || log_din[2] !== 32'h63) begin
            n_bad++;
            $display("FAIL controls_writes: %0d writes, expected 3 ending 63@2", log_addr.size());
        end
    endtask

    task automatic test_esc_invalid();
        clear_log();
        send_esc("Q");
        n_cmp++;
        if (log_addr.size() !== 0 || bus.cursor_x !== 7'd0) begin
            n_bad++;
            $display("FAIL esc_q_dropped: %0d writes x=%0d, expected 0 writes x=0", log_addr.size(), bus.cursor_x);
        end
        send_byte("a");
        n_cmp++;
        if (log_addr.size() !== 1 || log_addr[0] !== 0 || log_din[0] !== 32'h61 || bus.cursor_x !== 7'd1) begin
            n_bad++;
            $display("FAIL esc_q_then_a: %0d writes x=%0d, expected 61@0 and x=1", log_addr.size(), bus.cursor_x);
        end
    endtask

    task automatic test_esc_k();
        clear_log();
        send_esc("K");
        check_fill("esc_k", 1, 0, 0, 79);
        n_cmp++;
        if (bus.cursor_x !== 7'd1 || bus.cursor_y !== 5'd0) begin
            n_bad++;
            $display("FAIL esc_k_cursor: x=%0d y=%0d, expected 1 0", bus.cursor_x, bus.cursor_y);
        end
    endtask

    task automatic test_scroll();
        send_byte(8'h0D);
        for (int i = 0; i < 3; i++) send_esc("C");
        clear_log();
        for (int i = 0; i < 24; i++) send_byte(8'h0A);
        n_cmp++;
        if (log_addr.size() !== 0 || bus.cursor_y !== 5'd24 || bus.first_row !== 5'd0) begin
            n_bad++;
            $display("FAIL lf_down: %0d writes y=%0d first_row=%0d, expected 0 24 0",
                     log_addr.size(), bus.cursor_y, bus.first_row);
        end
        send_byte(8'h0A);
        n_cmp++;
        if (bus.first_row !== 5'd1) begin
            n_bad++;
            $display("FAIL scroll_first_row: got %0d, expected 1", bus.first_row);
        end
        check_fill("scroll", 0, 24, 1, 80);
        n_cmp++;
        if (bus.cursor_x !== 7'd3 || bus.cursor_y !== 5'd24) begin
            n_bad++;
            $display("FAIL scroll_cursor: x=%0d y=%0d, expected 3 24", bus.cursor_x, bus.cursor_y);
        end
        send_byte(8'h0D);
        clear_log();
        send_byte("Z");
        n_cmp++;
        if (log_addr.size() !== 1 || log_addr[0] !== 0 || log_din[0] !== 32'h5A) begin
            n_bad++;
            $display("FAIL scroll_z: %0d writes addr %0d, expected 5a@0",
                     log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : -1);
        end
    endtask

    task automatic test_esc_j();
        for (int i = 0; i < 23; i++) send_byte(8'h0A);
        n_cmp++;
        if (bus.first_row !== 5'd24) begin
            n_bad++;
            $display("FAIL first_row_24: got %0d, expected 24", bus.first_row);
        end
        send_esc("H");
        for (int i = 0; i < 5; i++) send_esc("B");
        for (int i = 0; i < 10; i++) send_esc("C");
        clear_log();
        send_esc("J");
        check_fill("esc_j", 10, 5, 24, 1590);
        n_cmp++;
        if (log_addr.size() == 0 || log_addr[0] !== 330) begin
            n_bad++;
            $display("FAIL esc_j_first: addr %0d, expected 330", (log_addr.size() > 0) ? log_addr[0] : -1);
        end
        n_cmp++;
        if (bus.cursor_x !== 7'd10 || bus.cursor_y !== 5'd5) begin
            n_bad++;
            $display("FAIL esc_j_cursor: x=%0d y=%0d, expected 10 5", bus.cursor_x, bus.cursor_y);
        end
    endtask

    task automatic test_row_wrap();
        send_esc("H");
        for (int i = 0; i < 70; i++) send_esc("C");
        clear_log();
        send_esc("J");
        check_fill("wrap", 70, 0, 24, 1930);
        n_cmp++;
        if (log_addr.size() < 11 || log_addr[9] !== 1999 || log_addr[10] !== 0) begin
            n_bad++;
            $display("FAIL wrap_edge: addrs %0d then %0d, expected 1999 then 0",
                     (log_addr.size() > 9) ? log_addr[9] : -1, (log_addr.size() > 10) ? log_addr[10] : -1);
        end
    endtask

    task automatic test_form_feed();
        clear_log();
        send_byte(8'h0C);
        check_fill("ff", 0, 0, 24, 2000);
        n_cmp++;
        if (bus.first_row !== 5'd0 || bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd0) begin
            n_bad++;
            $display("FAIL ff_home: first_row=%0d x=%0d y=%0d, expected 0 0 0",
                     bus.first_row, bus.cursor_x, bus.cursor_y);
        end
    endtask

    task automatic test_reset_mid_fill();
        for (int i = 0; i < 5; i++) send_esc("C");
        send_esc("B");
        send_esc("B");
        send_byte(8'h0C);
        repeat (50) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (bus.ready !== 1'b0 || bus.write_en !== 1'b0 || bus.cursor_x !== 7'd0 || bus.cursor_y !== 5'd0) begin
            n_bad++;
            $display("FAIL mid_fill_reset: ready=%b write_en=%b x=%0d y=%0d, expected 0 0 0 0",
                     bus.ready, bus.write_en, bus.cursor_x, bus.cursor_y);
        end
        clear_log();
        reset_n = 1'b1;
        check_fill("refill", 0, 0, 0, 2000);
    endtask

    initial begin
        @(negedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_no_wrap();
        test_controls();
        test_esc_invalid();
        test_esc_k();
        test_scroll();
        test_esc_j();
        test_row_wrap();
        test_form_feed();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
